bsg_comm_link_credit_tx: RTL and testbench

BSG_COMM_LINK_CREDIT_TX -- requirements
Module: bsg_comm_link_credit_tx

---
 rtl/bsg_comm_link_credit_tx.sv | 73 +++++++
 tb/tb_bsg_comm_link_credit_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_comm_link_credit_tx.sv
// Credit-based link transmitter: registers core words onto the link and tracks
// far-end FIFO space, refilled in blocks of TOK credits per token toggle.
module bsg_comm_link_credit_tx #(
  parameter int channel_width_p                 = 16,
  parameter int lg_input_fifo_depth_p           = 5,
  parameter int lg_credit_to_token_decimation_p = 3
) (
  input  logic                             clk_i,
  input  logic                             async_reset_n_i,
  input  logic                             en_i,
  input  logic                             v_i,
  input  logic [channel_width_p-1:0]       data_i,
  output logic                             ready_o,
  output logic                             io_valid_o,
  output logic [channel_width_p-1:0]       io_data_o,
  input  logic                             token_i,
  output logic [lg_input_fifo_depth_p:0]   credits_o,
  output logic                             overflow_o
);

  localparam int cnt_w  = lg_input_fifo_depth_p + 1;
  localparam int max_lp = 1 << lg_input_fifo_depth_p;
  localparam int tok_lp = 1 << lg_credit_to_token_decimation_p;

  localparam logic [cnt_w:0]   max_wide_lp = (cnt_w+1)'(max_lp);
  localparam logic [cnt_w:0]   tok_wide_lp = (cnt_w+1)'(tok_lp);
  localparam logic [cnt_w-1:0] max_cnt_lp  = cnt_w'(max_lp);

  logic [cnt_w-1:0]           r_credits;
  logic                       r_token;
  logic                       r_overflow;
  logic                       r_io_valid;
  logic [channel_width_p-1:0] r_io_data;

  logic                       w_send;
  logic                       w_tok_edge;
  logic [cnt_w:0]             w_credits_next;
  logic                       w_sat;

  // Handshake: a word moves when v_i & ready_o at a rising edge; ready_o never
  // looks at v_i, and v_i/data_i need not be held once the transfer happens.
  assign ready_o    = en_i & (r_credits != '0);
  assign w_send     = v_i & ready_o;
  assign w_tok_edge = token_i ^ r_token;

  // One bit of headroom so send, token and saturation resolve without wrap.
  assign w_credits_next = {1'b0, r_credits}
                        - {{cnt_w{1'b0}}, w_send}
                        + (w_tok_edge ? tok_wide_lp : '0);
  assign w_sat          = (w_credits_next > max_wide_lp);

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      r_credits  <= max_cnt_lp;
      r_token    <= 1'b0;
      r_overflow <= 1'b0;
      r_io_valid <= 1'b0;
      r_io_data  <= '0;
    end else begin
      r_token    <= token_i;
      r_credits  <= w_sat ? max_cnt_lp : w_credits_next[cnt_w-1:0];
      if (w_sat) r_overflow <= 1'b1;
      r_io_valid <= w_send;
      if (w_send) r_io_data <= data_i;
    end
  end

  assign io_valid_o = r_io_valid;
  assign io_data_o  = r_io_data;
  assign credits_o  = r_credits;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_bsg_comm_link_credit_tx.sv
// Directed bench for bsg_comm_link_credit_tx: drain, refill, simultaneous
// send/token, overflow, enable gating and mid-burst reset.
module tb_bsg_comm_link_credit_tx;

  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         en_i, v_i, token_i;
  logic [W-1:0] data_i;
  logic         ready_o, io_valid_o, overflow_o;
  logic [W-1:0] io_data_o;
  logic [5:0]   credits_o;

  bsg_comm_link_credit_tx dut (
    .clk_i           (clk),
    .async_reset_n_i (rst_n),
    .en_i            (en_i),
    .v_i             (v_i),
    .data_i          (data_i),
    .ready_o         (ready_o),
    .io_valid_o      (io_valid_o),
    .io_data_o       (io_data_o),
    .token_i         (token_i),
    .credits_o       (credits_o),
    .overflow_o      (overflow_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      data_i = W'($urandom_range(0, 16'hffff));
    end
  endtask

  task automatic toggle_token();
    token_i = ~token_i;
  endtask

  // scoreboard: accepted words in order, checked when they appear on the link
  logic [W-1:0] exp_q[$];
  int           total_pulses = 0;
  int           cur_run = 0;
  logic         prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_valid <= 1'b0;
    end else begin
      if (io_valid_o) begin
        total_pulses = total_pulses + 1;
        cur_run = prev_valid ? cur_run + 1 : 1;
        if (exp_q.size() == 0) chk("sb_empty", 32'(exp_q.size()), 1);
        else chk("sb_data", 32'(io_data_o), 32'(exp_q.pop_front()));
      end
      prev_valid <= io_valid_o;
      chk("no_underflow", 32'(ready_o && (credits_o == 6'd0)), 0);
      chk("cred_le_max", 32'(credits_o > 6'd32), 0);
      if (v_i && ready_o) exp_q.push_back(data_i);
    end
  end

  int base;

  initial begin
    en_i = 1'b0; v_i = 1'b0; token_i = 1'b0; data_i = '0;
    #2 rst_n = 1'b0;
    tick(2);
    chk("rst_credits", 32'(credits_o), 32);
    chk("rst_io_valid", 32'(io_valid_o), 0);
    chk("rst_io_data", 32'(io_data_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);
    chk("rst_ready_en0", 32'(ready_o), 0);
    rst_n = 1'b1;
    en_i = 1'b1;
    #1 chk("ready_after_en", 32'(ready_o), 1);

    // burst drain
    base = total_pulses;
    v_i = 1'b1;
    tick(40);
    v_i = 1'b0;
    tick(1);
    chk("drain_pulses", 32'(total_pulses - base), 32);
    chk("drain_consecutive", 32'(cur_run), 32);
    chk("drain_ready", 32'(ready_o), 0);
    chk("drain_credits", 32'(credits_o), 0);

    // token refill
    toggle_token();
    tick(2);
    chk("refill_credits", 32'(credits_o), 8);
    base = total_pulses;
    v_i = 1'b1;
    tick(12);
    v_i = 1'b0;
    tick(1);
    chk("refill_pulses", 32'(total_pulses - base), 8);
    chk("refill_empty", 32'(credits_o), 0);

    // simultaneous send and token edge
    toggle_token();
    tick(1);
    v_i = 1'b1;
    tick(3);
    chk("simul_pre", 32'(credits_o), 5);
    toggle_token();
    tick(1);
    v_i = 1'b0;
    chk("simul_credits", 32'(credits_o), 12);
    chk("simul_no_ovf", 32'(overflow_o), 0);

    // overflow
    v_i = 1'b1;
    tick(6);
    v_i = 1'b0;
    repeat (3) begin
      toggle_token();
      tick(1);
    end
    chk("ovf_pre_credits", 32'(credits_o), 30);
    chk("ovf_pre_flag", 32'(overflow_o), 0);
    toggle_token();
    tick(1);
    chk("ovf_sat_credits", 32'(credits_o), 32);
    chk("ovf_flag", 32'(overflow_o), 1);
    v_i = 1'b1;
    tick(4);
    v_i = 1'b0;
    chk("ovf_after_send_cr", 32'(credits_o), 28);
    chk("ovf_sticky", 32'(overflow_o), 1);

    // enable gating
    v_i = 1'b1;
    tick(12);
    v_i = 1'b0;
    tick(1);
    chk("gate_pre_credits", 32'(credits_o), 16);
    en_i = 1'b0;
    v_i = 1'b1;
    base = total_pulses;
    toggle_token();
    tick(1);
    toggle_token();
    tick(2);
    chk("gate_ready", 32'(ready_o), 0);
    chk("gate_credits", 32'(credits_o), 32);
    chk("gate_pulses", 32'(total_pulses - base), 0);
    v_i = 1'b0;
    en_i = 1'b1;

    // mid-burst reset
    v_i = 1'b1;
    tick(5);
    chk("mid_pre_credits", 32'(credits_o), 27);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(io_valid_o), 0);
    chk("mid_async_credits", 32'(credits_o), 32);
    chk("mid_async_ovf", 32'(overflow_o), 0);
    chk("mid_async_data", 32'(io_data_o), 0);
    v_i = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("mid_post_valid", 32'(io_valid_o), 0);
    chk("mid_post_credits", 32'(credits_o), 32);
    base = total_pulses;
    v_i = 1'b1;
    tick(6);
    v_i = 1'b0;
    tick(2);
    chk("mid_resume_pulses", 32'(total_pulses - base), 6);
    chk("mid_resume_credits", 32'(credits_o), 26);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
